cdb_broadcast_arbiter: RTL and testbench



---
 rtl/cdb_broadcast_arbiter_if.sv | 52 +++++
 rtl/cdb_broadcast_arbiter.sv | 175 +++++++++++++++++
 tb/tb_cdb_broadcast_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cdb_broadcast_arbiter_if.sv
// ============================================================================
// Module   : cdb_broadcast_arbiter_if
// Brief    : Functional-unit result ports plus common-data-bus broadcast lines
//            shared between cdb_broadcast_arbiter and its surroundings.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface cdb_broadcast_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 4,
    parameter int NUM_FU     = 4
);
    // Functional-unit side: FU i owns slice i of each packed vector.
    logic [NUM_FU-1:0]            fu_req;
    logic [NUM_FU*TAG_WIDTH-1:0]  fu_tag;
    logic [NUM_FU*DATA_WIDTH-1:0] fu_data;
    logic [NUM_FU-1:0]            fu_grant;

    // Arbitration unit and snoopers.
    logic                         allowBroadcast;
    logic                         broadcastDataAvailable;
    logic [TAG_WIDTH-1:0]         broadcastDestinationTag;
    logic [DATA_WIDTH-1:0]        broadcastDestinationData;
    logic                         ongoingBroadcast;

    modport master (
        input  fu_req,
        input  fu_tag,
        input  fu_data,
        output fu_grant,
        input  allowBroadcast,
        output broadcastDataAvailable,
        output broadcastDestinationTag,
        output broadcastDestinationData,
        output ongoingBroadcast
    );

    modport slave (
        output fu_req,
        output fu_tag,
        output fu_data,
        input  fu_grant,
        output allowBroadcast,
        input  broadcastDataAvailable,
        input  broadcastDestinationTag,
        input  broadcastDestinationData,
        input  ongoingBroadcast
    );
endinterface

`default_nettype wire

// File: rtl/cdb_broadcast_arbiter.sv
// ============================================================================
// Module   : cdb_broadcast_arbiter
// Brief    : Round-robin arbiter sharing one CDB broadcast slot among NUM_FU
//            functional units. Define CDB_PERF_COUNTERS_EN to add the
//            broadcast / stall performance counters.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module cdb_broadcast_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 4,
    parameter int NUM_FU     = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  wire                          clk,
    input  wire                          rst,
    cdb_broadcast_arbiter_if.master      bus
`ifdef CDB_PERF_COUNTERS_EN
    ,
    output logic [CNT_WIDTH-1:0]         perf_broadcasts,
    output logic [CNT_WIDTH-1:0]         perf_stall_cycles
`endif
);

    localparam int PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_PRESENT   = 2'd1,
        ST_BROADCAST = 2'd2
    } state_t;

    state_t                state_q,     state_d;
    logic [PTR_W-1:0]      rr_ptr_q,    rr_ptr_d;
    logic [TAG_WIDTH-1:0]  slot_tag_q,  slot_tag_d;
    logic [DATA_WIDTH-1:0] slot_data_q, slot_data_d;
    logic                  avail_q,     avail_d;
    logic                  ongoing_q,   ongoing_d;

    logic                  found;
    logic [PTR_W-1:0]      winner;
    logic [TAG_WIDTH-1:0]  win_tag;
    logic [DATA_WIDTH-1:0] win_data;
    logic                  window_open;
    logic                  fire;
    logic [NUM_FU-1:0]     grant;

    // Rotating priority scan: first requester at or above rr_ptr, wrapping.
    always_comb begin : winner_scan
        int idx;
        found    = 1'b0;
        winner   = '0;
        win_tag  = '0;
        win_data = '0;
        idx      = 0;
        for (int k = 0; k < NUM_FU; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NUM_FU) begin
                idx = idx - NUM_FU;
            end
            if (!found && bus.fu_req[idx]) begin
                found    = 1'b1;
                winner   = PTR_W'(idx);
                win_tag  = bus.fu_tag[idx*TAG_WIDTH +: TAG_WIDTH];
                win_data = bus.fu_data[idx*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // The slot can accept a new result whenever it is empty or being drained.
    assign window_open = (state_q == ST_IDLE) || (state_q == ST_BROADCAST);
    assign fire        = rst && window_open && found;

    always_comb begin : grant_decode
        grant = '0;
        if (fire) begin
            grant = NUM_FU'(1) << winner;
        end
    end

    always_comb begin : next_state
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        slot_tag_d  = slot_tag_q;
        slot_data_d = slot_data_q;

        case (state_q)
            ST_IDLE, ST_BROADCAST: begin
                if (fire) begin
                    state_d     = ST_PRESENT;
                    slot_tag_d  = win_tag;
                    slot_data_d = win_data;
                    rr_ptr_d    = (winner == PTR_W'(NUM_FU - 1)) ? '0 : winner + 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PRESENT: begin
                if (bus.allowBroadcast) begin
                    state_d = ST_BROADCAST;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // An empty slot drives zeros onto the bus.
        if (state_d == ST_IDLE) begin
            slot_tag_d  = '0;
            slot_data_d = '0;
        end

        avail_d   = (state_d != ST_IDLE);
        ongoing_d = (state_d == ST_BROADCAST);
    end

    always_ff @(posedge clk) begin : state_regs
        if (!rst) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= '0;
            slot_tag_q  <= '0;
            slot_data_q <= '0;
            avail_q     <= 1'b0;
            ongoing_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            slot_tag_q  <= slot_tag_d;
            slot_data_q <= slot_data_d;
            avail_q     <= avail_d;
            ongoing_q   <= ongoing_d;
        end
    end

    assign bus.fu_grant                 = grant;
    assign bus.broadcastDataAvailable   = avail_q;
    assign bus.ongoingBroadcast         = ongoing_q;
    assign bus.broadcastDestinationTag  = slot_tag_q;
    assign bus.broadcastDestinationData = slot_data_q;

`ifdef CDB_PERF_COUNTERS_EN
    logic [CNT_WIDTH-1:0] perf_bc_q,    perf_bc_d;
    logic [CNT_WIDTH-1:0] perf_stall_q, perf_stall_d;

    // Both counters stick at all-ones rather than wrapping.
    always_comb begin : perf_next
        perf_bc_d    = perf_bc_q;
        perf_stall_d = perf_stall_q;
        if ((state_q == ST_BROADCAST) && (perf_bc_q != '1)) begin
            perf_bc_d = perf_bc_q + CNT_WIDTH'(1);
        end
        if ((state_q == ST_PRESENT) && !bus.allowBroadcast && (perf_stall_q != '1)) begin
            perf_stall_d = perf_stall_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin : perf_regs
        if (!rst) begin
            perf_bc_q    <= '0;
            perf_stall_q <= '0;
        end else begin
            perf_bc_q    <= perf_bc_d;
            perf_stall_q <= perf_stall_d;
        end
    end

    assign perf_broadcasts   = perf_bc_q;
    assign perf_stall_cycles = perf_stall_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_cdb_broadcast_arbiter.sv
// ============================================================================
// Module   : tb_cdb_broadcast_arbiter
// Brief    : Directed self-checking bench for cdb_broadcast_arbiter.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_cdb_broadcast_arbiter;

    localparam int DW = 32;
    localparam int TW = 4;
    localparam int NF = 4;
`ifdef CDB_PERF_COUNTERS_EN
    localparam int CW = 4;
`else
    localparam int CW = 16;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cdb_broadcast_arbiter_if #(.DATA_WIDTH(DW), .TAG_WIDTH(TW), .NUM_FU(NF)) bus();

`ifdef CDB_PERF_COUNTERS_EN
    logic [CW-1:0] perf_broadcasts;
    logic [CW-1:0] perf_stall_cycles;
`endif

    cdb_broadcast_arbiter #(
        .DATA_WIDTH(DW), .TAG_WIDTH(TW), .NUM_FU(NF), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef CDB_PERF_COUNTERS_EN
        ,
        .perf_broadcasts(perf_broadcasts),
        .perf_stall_cycles(perf_stall_cycles)
`endif
    );

    int passed = 0;
    int total  = 0;

    // {available, ongoing, tag, data}
    logic [1+1+TW+DW-1:0] obs;
    assign obs = {bus.broadcastDataAvailable, bus.ongoingBroadcast,
                  bus.broadcastDestinationTag, bus.broadcastDestinationData};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_fu(input int i, input logic [TW-1:0] t, input logic [DW-1:0] d);
        bus.fu_tag[i*TW +: TW]  = t;
        bus.fu_data[i*DW +: DW] = d;
    endtask

    task automatic apply_reset();
        rst                = 1'b0;
        bus.fu_req         = '0;
        bus.allowBroadcast = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        logic [NF-1:0] g;
        rst                = 1'b0;
        bus.fu_req         = 4'b1111;
        bus.fu_tag         = '0;
        bus.fu_data        = '0;
        bus.allowBroadcast = 1'b1;
        tick();
        tick();
        g = bus.fu_grant;
        total++;
        if (g !== 4'b0000) $display("FAIL reset_grant: got %b expected 0000", g);
        else passed++;
        total++;
        if (obs !== '0) $display("FAIL reset_outputs: got %h expected 0", obs);
        else passed++;
        bus.fu_req = '0;
        rst        = 1'b1;
        tick();
    endtask

    task automatic test_single();
        set_fu(0, 4'h3, 32'hDEADBEEF);
        bus.fu_req         = 4'b0001;
        bus.allowBroadcast = 1'b1;
        #1;
        total++;
        if (bus.fu_grant !== 4'b0001) $display("FAIL single_grant: got %b expected 0001", bus.fu_grant);
        else passed++;
        tick();
        bus.fu_req = '0;
        total++;
        if (obs !== {1'b1, 1'b0, 4'h3, 32'hDEADBEEF})
            $display("FAIL single_present: got %h expected %h", obs, {1'b1, 1'b0, 4'h3, 32'hDEADBEEF});
        else passed++;
        tick();
        total++;
        if (obs !== {1'b1, 1'b1, 4'h3, 32'hDEADBEEF})
            $display("FAIL single_broadcast: got %h expected %h", obs, {1'b1, 1'b1, 4'h3, 32'hDEADBEEF});
        else passed++;
        tick();
        total++;
        if (obs !== '0) $display("FAIL single_idle: got %h expected 0", obs);
        else passed++;
    endtask

    task automatic test_back_to_back();
        logic [NF-1:0] exp_g;
        logic [TW-1:0] exp_t;
        apply_reset();
        for (int i = 0; i < NF; i++) set_fu(i, TW'(8 + i), 32'hA000_0000 + DW'(i));
        bus.fu_req         = 4'b1111;
        bus.allowBroadcast = 1'b1;
        for (int c = 0; c < 9; c++) begin
            #1;
            exp_g = (c % 2 == 0) ? (4'b0001 << ((c / 2) % 4)) : 4'b0000;
            total++;
            if (bus.fu_grant !== exp_g)
                $display("FAIL b2b_grant[%0d]: got %b expected %b", c, bus.fu_grant, exp_g);
            else passed++;
            tick();
            total++;
            if (bus.ongoingBroadcast !== (c % 2 == 1))
                $display("FAIL b2b_ongoing[%0d]: got %b expected %b", c, bus.ongoingBroadcast, (c % 2 == 1));
            else passed++;
            if (c % 2 == 0) begin
                exp_t = TW'(8 + (c / 2) % 4);
                total++;
                if (bus.broadcastDestinationTag !== exp_t)
                    $display("FAIL b2b_tag[%0d]: got %h expected %h", c, bus.broadcastDestinationTag, exp_t);
                else passed++;
            end
        end
        bus.fu_req = '0;
        tick();
        tick();
    endtask

    task automatic test_stall();
        apply_reset();
        set_fu(0, 4'h5, 32'h5555_0005);
        set_fu(1, 4'h6, 32'h6666_0006);
        set_fu(2, 4'h7, 32'h7777_0007);
        bus.fu_req         = 4'b0001;
        bus.allowBroadcast = 1'b0;
        #1;
        total++;
        if (bus.fu_grant !== 4'b0001) $display("FAIL stall_load_grant: got %b expected 0001", bus.fu_grant);
        else passed++;
        tick();
        bus.fu_req = 4'b0110;
        for (int c = 0; c < 6; c++) begin
            #1;
            total++;
            if (bus.fu_grant !== 4'b0000)
                $display("FAIL stall_grant[%0d]: got %b expected 0000", c, bus.fu_grant);
            else passed++;
            tick();
            total++;
            if (obs !== {1'b1, 1'b0, 4'h5, 32'h5555_0005})
                $display("FAIL stall_frozen[%0d]: got %h expected %h", c, obs, {1'b1, 1'b0, 4'h5, 32'h5555_0005});
            else passed++;
        end
        bus.allowBroadcast = 1'b1;
        tick();
        total++;
        if (obs !== {1'b1, 1'b1, 4'h5, 32'h5555_0005})
            $display("FAIL stall_release: got %h expected %h", obs, {1'b1, 1'b1, 4'h5, 32'h5555_0005});
        else passed++;
        #1;
        total++;
        if (bus.fu_grant !== 4'b0010) $display("FAIL stall_next_grant: got %b expected 0010", bus.fu_grant);
        else passed++;
        tick();
        bus.fu_req = '0;
        tick();
        tick();
    endtask

    task automatic test_fairness();
        apply_reset();
        set_fu(0, 4'hA, 32'h0000_000A);
        set_fu(1, 4'hB, 32'h0000_000B);
        set_fu(3, 4'hD, 32'h0000_000D);
        bus.fu_req         = 4'b0010;
        bus.allowBroadcast = 1'b1;
        #1;
        total++;
        if (bus.fu_grant !== 4'b0010) $display("FAIL fair_first: got %b expected 0010", bus.fu_grant);
        else passed++;
        tick();
        bus.fu_req = '0;
        tick();
        bus.fu_req = 4'b1001;
        #1;
        total++;
        if (bus.fu_grant !== 4'b1000) $display("FAIL fair_skip: got %b expected 1000", bus.fu_grant);
        else passed++;
        tick();
        bus.fu_req = 4'b0001;
        #1;
        total++;
        if (bus.fu_grant !== 4'b0000) $display("FAIL fair_closed: got %b expected 0000", bus.fu_grant);
        else passed++;
        total++;
        if (bus.broadcastDestinationTag !== 4'hD)
            $display("FAIL fair_tag3: got %h expected d", bus.broadcastDestinationTag);
        else passed++;
        tick();
        #1;
        total++;
        if (bus.fu_grant !== 4'b0001) $display("FAIL fair_wrap: got %b expected 0001", bus.fu_grant);
        else passed++;
        tick();
        bus.fu_req = '0;
        total++;
        if (bus.broadcastDestinationTag !== 4'hA)
            $display("FAIL fair_tag0: got %h expected a", bus.broadcastDestinationTag);
        else passed++;
        tick();
        tick();
    endtask

    task automatic test_reset_mid();
        apply_reset();
        set_fu(1, 4'h9, 32'h9999_9999);
        set_fu(2, 4'h2, 32'h2222_2222);
        bus.fu_req         = 4'b0010;
        bus.allowBroadcast = 1'b1;
        tick();
        bus.fu_req = 4'b0100;
        tick();
        total++;
        if (bus.ongoingBroadcast !== 1'b1) $display("FAIL rmid_pre: got %b expected 1", bus.ongoingBroadcast);
        else passed++;
        rst = 1'b0;
        #1;
        total++;
        if (bus.fu_grant !== 4'b0000) $display("FAIL rmid_grant: got %b expected 0000", bus.fu_grant);
        else passed++;
        tick();
        total++;
        if (obs !== '0) $display("FAIL rmid_outputs: got %h expected 0", obs);
        else passed++;
        rst        = 1'b1;
        bus.fu_req = 4'b1111;
        #1;
        total++;
        if (bus.fu_grant !== 4'b0001) $display("FAIL rmid_ptr: got %b expected 0001", bus.fu_grant);
        else passed++;
        tick();
        bus.fu_req = '0;
        tick();
        tick();
    endtask

`ifdef CDB_PERF_COUNTERS_EN
    task automatic test_perf();
        apply_reset();
        set_fu(0, 4'h1, 32'h0000_0001);
        for (int r = 0; r < 3; r++) begin
            bus.fu_req         = 4'b0001;
            bus.allowBroadcast = (r != 0);
            tick();
            bus.fu_req = '0;
            if (r == 0) begin
                repeat (4) tick();
                bus.allowBroadcast = 1'b1;
            end
            tick();
            tick();
        end
        total++;
        if (perf_broadcasts !== 4'd3) $display("FAIL perf_bc: got %0d expected 3", perf_broadcasts);
        else passed++;
        total++;
        if (perf_stall_cycles !== 4'd4) $display("FAIL perf_stall: got %0d expected 4", perf_stall_cycles);
        else passed++;
        apply_reset();
        bus.fu_req = 4'b0001;
        tick();
        bus.fu_req = '0;
        repeat (20) tick();
        total++;
        if (perf_stall_cycles !== 4'd15) $display("FAIL perf_sat: got %0d expected 15", perf_stall_cycles);
        else passed++;
        bus.allowBroadcast = 1'b1;
        tick();
        tick();
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_fairness();
        test_reset_mid();
`ifdef CDB_PERF_COUNTERS_EN
        test_perf();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire
